radar_mem_arbiter: RTL and testbench
====================================

# radar_mem_arbiter

Two-master arbiter and sequencer in front of the radar core's single-port 32-bit on-chip RAM (DEPTH words, 1-cycle read latency). It shares the one RAM port between the VGA display fetcher (m0, read-only, latency-critical) and the Nios/sonar data path (m1, read/write). Fixed priority favours m0, and a starvation counter bounds m1 wait time. It also applies out-of-range protection and freeze gating before the RAM's Avalon-MM slave.

## Interface
- ADDR_W, 16, word-address width on all ports
- DEPTH, 35240, number of implemented RAM words; valid addresses are 0..DEPTH-1
- MAX_WAIT, 8, consecutive denied m1 cycles before m1 overrides m0 (1..255)
- clk  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- freeze  in  1  high: no grants issued, mem_clken low
- m0_read  in  1  display read request
- m0_address  in  ADDR_W  display word address
- m0_waitrequest  out  1  m0_read & ~grant0
- m0_readdata  out  32  read data, valid when m0_readdatavalid
- m0_readdatavalid  out  1  one-cycle strobe, 1 cycle after m0 grant
- m1_read, m1_write  in  1 each  CPU request; both high is illegal and is treated as write
- m1_address  in  ADDR_W  CPU word address
- m1_byteenable  in  4  write byte lanes
- m1_writedata  in  32  write data
- m1_waitrequest  out  1  (m1_read|m1_write) & ~grant1
- m1_readdata  out  32  read data
- m1_readdatavalid  out  1  one-cycle strobe, 1 cycle after m1 read grant
- mem_address  out  ADDR_W  to RAM
- mem_byteenable  out  4  to RAM (4'hF for m0)
- mem_chipselect, mem_write  out  1 each  to RAM
- mem_writedata  out  32  to RAM
- mem_clken  out  1  ~freeze
- mem_readdata  in  32  RAM q, valid the cycle after address presented
- err_oob  out  1  sticky: an out-of-range access occurred
- err_clr  in  1  clears err_oob

## Operation
- Grant logic is combinational from requests, freeze, reset_n and starve_cnt. At most one grant per cycle.
- Grant rules:
  - If freeze or reset_n low: no grant.
  - Else if m1 requests and starve_cnt == MAX_WAIT: grant1.
  - Else if m0_read: grant0.
  - Else if m1 requests: grant1.
- The granted master's address, byteenable and data drive the mem_* outputs in the same cycle. mem_chipselect = grant & in-range.
- Out-of-range (address >= DEPTH):
  - mem_chipselect stays 0, so writes are dropped.
  - A read still returns readdatavalid with readdata = 0.
  - err_oob is set on the next edge.
- starve_cnt (8 bit):
  - Increments when m1 requests and is not granted, saturating at MAX_WAIT.
  - Clears when m1 is granted or m1 is not requesting.
  - Holds while freeze is high.
- Read return pipeline: registers rdv0, rdv1 and oob_q, set from the granted read. The next cycle, the selected master's readdata is mem_readdata, or 0 if oob_q. The non-selected master's readdata is 0.
- err_oob: err_clr has priority over a new set in the same cycle.

## Timing
- Reset values: rdv0, rdv1, oob_q, err_oob = 0; starve_cnt = 0. While reset_n is low, all grants = 0, so mem_chipselect = 0 and each waitrequest equals its request.
- Read latency: exactly 1 cycle from the grant edge to readdatavalid. Back-to-back granted reads give back-to-back valid strobes.
- Write: completes in the grant cycle (waitrequest low); no response.
- Worst-case m1 wait under continuous m0 load: MAX_WAIT cycles; grant on cycle MAX_WAIT+1. m0 then waits exactly one cycle.
- Freeze asserted in the cycle after a read grant: readdatavalid still fires, because the RAM's held output stays valid.
- Reset mid-read: the pending readdatavalid is cancelled.

## Structure
- Shared package radar_mem_pkg: ADDR_W, DEPTH and the grant encoding constants (GNT_NONE, GNT_M0, GNT_M1).
- One natural sub-module: radar_mem_starve_ctr (saturating counter with clear and hold). Everything else is flat.

## Test plan
- m0 reads 0x0010 alone, RAM preloaded with 0xDEADBEEF there → mem_chipselect for 1 cycle, then m0_readdatavalid = 1 with m0_readdata = 0xDEADBEEF on the next cycle.
- m0 reads continuously while m1 writes 0x0004, byteenable 4'b0011, data 0x12345678 → m1_waitrequest high for 8 cycles, granted on the 9th; m0 stalled that cycle only; readback returns 0x????5678 with the upper bytes preserved.
- Both masters idle, then simultaneous m0 read and m1 read with starve_cnt = 0 → m0 granted first, m1 next cycle; valid strobes in consecutive cycles, no overlap.
- m1 writes 35240 → no mem_chipselect, err_oob = 1 next cycle. m1 then reads 40000 → readdatavalid with readdata 0. err_clr → err_oob = 0.
- freeze held high 5 cycles while both masters request → no grants, mem_clken = 0, starve_cnt unchanged. Release → normal arbitration resumes.
- reset_n pulsed low in the cycle after an m1 read grant → no m1_readdatavalid; all registers return to 0.

Source files
------------

// File: rtl/radar_mem_pkg.sv
// radar_mem_pkg: shared constants for the radar RAM arbiter
package radar_mem_pkg;
   localparam int ADDR_W = 16;
   localparam int DEPTH = 35240;
   localparam logic [1:0] GNT_NONE = 2'd0;
   localparam logic [1:0] GNT_M0 = 2'd1;
   localparam logic [1:0] GNT_M1 = 2'd2;
endpackage

// File: rtl/radar_mem_starve_ctr.sv
// radar_mem_starve_ctr: saturating m1 wait counter with clear and hold
module radar_mem_starve_ctr #(
   parameter int MAX_WAIT = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req,
   input  logic       gnt,
   input  logic       hold,
   output logic [7:0] cnt
);
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) cnt <= '0;
      else if (!hold) cnt <= (!req || gnt) ? '0 : (cnt == 8'(MAX_WAIT)) ? cnt : cnt + 8'd1;
endmodule

// File: rtl/radar_mem_arbiter.sv
// radar_mem_arbiter: two-master fixed-priority RAM arbiter with m1 anti-starvation,
// out-of-range protection and freeze gating
module radar_mem_arbiter
   import radar_mem_pkg::*;
#(
   parameter int MAX_WAIT = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              freeze,
   input  logic              m0_read,
   input  logic [ADDR_W-1:0] m0_address,
   output logic              m0_waitrequest,
   output logic [31:0]       m0_readdata,
   output logic              m0_readdatavalid,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic [3:0]        m1_byteenable,
   input  logic [31:0]       m1_writedata,
   output logic              m1_waitrequest,
   output logic [31:0]       m1_readdata,
   output logic              m1_readdatavalid,
   output logic [ADDR_W-1:0] mem_address,
   output logic [3:0]        mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [31:0]       mem_writedata,
   output logic              mem_clken,
   input  logic [31:0]       mem_readdata,
   output logic              err_oob,
   input  logic              err_clr
);
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
   logic [1:0] gnt;
   logic [7:0] starve_cnt;
   logic m1_req, g0, g1, rd_gnt, oob;
   logic rdv0, rdv1, oob_q;

   radar_mem_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_starve (
      .clk(clk),
      .reset_n(reset_n),
      .req(m1_req),
      .gnt(g1),
      .hold(freeze),
      .cnt(starve_cnt)
   );

   always_comb begin
      m1_req = m1_read | m1_write;
      gnt = (freeze || !reset_n) ? GNT_NONE :
            (m1_req && starve_cnt == 8'(MAX_WAIT)) ? GNT_M1 :
            m0_read ? GNT_M0 :
            m1_req ? GNT_M1 : GNT_NONE;
      g0 = gnt == GNT_M0;
      g1 = gnt == GNT_M1;
      // simultaneous read+write from m1 is handled as a write
      rd_gnt = g0 | (g1 & ~m1_write);
      mem_address = g1 ? m1_address : m0_address;
      oob = {1'b0, mem_address} >= DEPTH_L;
      mem_byteenable = g1 ? m1_byteenable : 4'hF;
      mem_chipselect = (g0 | g1) & ~oob;
      mem_write = g1 & m1_write;
      mem_writedata = m1_writedata;
      mem_clken = ~freeze;
      m0_waitrequest = m0_read & ~g0;
      m1_waitrequest = m1_req & ~g1;
      m0_readdatavalid = rdv0;
      m1_readdatavalid = rdv1;
      m0_readdata = (rdv0 && !oob_q) ? mem_readdata : '0;
      m1_readdata = (rdv1 && !oob_q) ? mem_readdata : '0;
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         rdv0 <= 1'b0;
         rdv1 <= 1'b0;
         oob_q <= 1'b0;
         err_oob <= 1'b0;
      end else begin
         rdv0 <= g0;
         rdv1 <= g1 & ~m1_write;
         oob_q <= rd_gnt & oob;
         err_oob <= err_clr ? 1'b0 : err_oob | ((g0 | g1) & oob);
      end
endmodule

// File: tb/tb_radar_mem_arbiter.sv
// tb_radar_mem_arbiter: directed + random scoreboard bench for radar_mem_arbiter
module tb_radar_mem_arbiter;
   import radar_mem_pkg::*;
   localparam int MAX_WAIT = 8;

   typedef struct {
      logic [31:0] d;
      int          c;
   } exp_t;

   logic clk, reset_n, freeze, err_clr;
   logic m0_read, m0_waitrequest, m0_readdatavalid;
   logic [ADDR_W-1:0] m0_address, m1_address, mem_address;
   logic [31:0] m0_readdata, m1_readdata, m1_writedata, mem_writedata, mem_readdata;
   logic m1_read, m1_write, m1_waitrequest, m1_readdatavalid;
   logic [3:0] m1_byteenable, mem_byteenable;
   logic mem_chipselect, mem_write, mem_clken, err_oob;

   int checks = 0, fails = 0, cyc = 0;
   exp_t q [2][$];
   logic [31:0] ram [0:DEPTH-1];
   logic [31:0] ref_mem [0:DEPTH-1];
   bit exp_err;
   int m1_wait;
   bit d0, d1;

   radar_mem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .reset_n(reset_n), .freeze(freeze),
      .m0_read(m0_read), .m0_address(m0_address), .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
      .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
      .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
      .m1_readdatavalid(m1_readdatavalid),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable),
      .mem_chipselect(mem_chipselect), .mem_write(mem_write),
      .mem_writedata(mem_writedata), .mem_clken(mem_clken),
      .mem_readdata(mem_readdata), .err_oob(err_oob), .err_clr(err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] init_val(int i);
      return (i == 16) ? 32'hDEAD_BEEF : (32'(i) * 32'h0101_0101) ^ 32'h5A5A_0000;
   endfunction

   function automatic bit inr(logic [ADDR_W-1:0] a);
      return int'(a) < DEPTH;
   endfunction

   function automatic logic [ADDR_W-1:0] rand_addr();
      int r;
      r = $urandom_range(0, 15);
      if (r < 10) return ADDR_W'($urandom_range(0, 31));
      if (r < 12) return ADDR_W'($urandom_range(DEPTH - 1, DEPTH));
      if (r < 14) return ADDR_W'($urandom_range(DEPTH, 65535));
      return ADDR_W'($urandom_range(0, DEPTH - 1));
   endfunction

   task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (!ok) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // RAM: 1-cycle read latency, output held while clken is low
   initial begin
      for (int i = 0; i < DEPTH; i++) ram[i] = init_val(i);
      mem_readdata = '0;
      forever begin
         @(posedge clk);
         if (mem_clken) begin
            if (mem_chipselect && mem_write)
               for (int b = 0; b < 4; b++)
                  if (mem_byteenable[b]) ram[mem_address][8*b +: 8] = mem_writedata[8*b +: 8];
            mem_readdata <= inr(mem_address) ? ram[mem_address] : $urandom;
         end
      end
   end

   // acceptance observer: updates the reference memory and pushes expected reads
   initial begin
      bit a0, a1, m1r;
      exp_t e;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
      exp_err = 0;
      m1_wait = 0;
      forever begin
         @(negedge clk);
         m1r = m1_read | m1_write;
         if (!reset_n) begin
            exp_err = 0;
            m1_wait = 0;
            chk(err_oob == 0, "rst_err_oob", 32'(err_oob), 0);
            chk(mem_chipselect == 0, "rst_chipselect", 32'(mem_chipselect), 0);
            chk(m0_waitrequest == m0_read, "rst_m0_wait", 32'(m0_waitrequest), 32'(m0_read));
            chk(m1_waitrequest == m1r, "rst_m1_wait", 32'(m1_waitrequest), 32'(m1r));
         end else begin
            chk(err_oob == exp_err, "err_oob", 32'(err_oob), 32'(exp_err));
            chk(mem_clken == !freeze, "mem_clken", 32'(mem_clken), 32'(!freeze));
            a0 = m0_read && !m0_waitrequest;
            a1 = m1r && !m1_waitrequest;
            if (freeze) chk(!a0 && !a1 && !mem_chipselect, "freeze_no_grant", {a0, a1, mem_chipselect}, 0);
            if (m0_read && m1r && !freeze) chk(a0 != a1, "one_grant", {a0, a1}, 0);
            if (a0) begin
               chk(mem_address == m0_address, "m0_addr", 32'(mem_address), 32'(m0_address));
               chk(mem_chipselect == inr(m0_address), "m0_cs", 32'(mem_chipselect), 32'(inr(m0_address)));
               chk(mem_write == 0 && mem_byteenable == 4'hF, "m0_ctl", {mem_write, mem_byteenable}, 32'hF);
               e.d = inr(m0_address) ? ref_mem[m0_address] : 0;
               e.c = cyc;
               q[0].push_back(e);
            end
            if (a1) begin
               chk(mem_address == m1_address, "m1_addr", 32'(mem_address), 32'(m1_address));
               chk(mem_chipselect == inr(m1_address), "m1_cs", 32'(mem_chipselect), 32'(inr(m1_address)));
               chk(mem_write == m1_write, "m1_write", 32'(mem_write), 32'(m1_write));
               if (m1_write) begin
                  if (inr(m1_address))
                     for (int b = 0; b < 4; b++)
                        if (m1_byteenable[b]) ref_mem[m1_address][8*b +: 8] = m1_writedata[8*b +: 8];
               end else begin
                  e.d = inr(m1_address) ? ref_mem[m1_address] : 0;
                  e.c = cyc;
                  q[1].push_back(e);
               end
            end
            if (!m1r) m1_wait = 0;
            else if (!freeze) begin
               m1_wait = a1 ? 0 : m1_wait + 1;
               if (!a1) chk(m1_wait <= MAX_WAIT, "starve_bound", m1_wait, MAX_WAIT);
            end
            exp_err = err_clr ? 0 : exp_err | (a0 && !inr(m0_address)) | (a1 && !inr(m1_address));
         end
      end
   end

   // response monitor: pops the scoreboard whenever a read strobe appears
   initial forever begin
      @(negedge clk);
      if (!reset_n) begin
         chk(!m0_readdatavalid && !m1_readdatavalid, "rst_rdv", {m0_readdatavalid, m1_readdatavalid}, 0);
         q[0].delete();
         q[1].delete();
      end else
         for (int i = 0; i < 2; i++) begin
            logic rv;
            logic [31:0] rd;
            exp_t e;
            rv = i ? m1_readdatavalid : m0_readdatavalid;
            rd = i ? m1_readdata : m0_readdata;
            if (rv) begin
               if (q[i].size() == 0) chk(0, i ? "m1_unexpected_rdv" : "m0_unexpected_rdv", 1, 0);
               else begin
                  e = q[i].pop_front();
                  chk(rd == e.d, i ? "m1_rdata" : "m0_rdata", rd, e.d);
                  chk(e.c == cyc - 1, i ? "m1_latency" : "m0_latency", cyc - e.c, 1);
               end
            end else begin
               chk(rd == 0, i ? "m1_idle_rdata" : "m0_idle_rdata", rd, 0);
               if (q[i].size() > 0 && q[i][0].c <= cyc - 1) begin
                  chk(0, i ? "m1_missing_rdv" : "m0_missing_rdv", 0, 1);
                  void'(q[i].pop_front());
               end
            end
         end
   end

   task automatic m0_rd(input logic [ADDR_W-1:0] a, output int acc);
      m0_address = a;
      m0_read = 1;
      acc = -1;
      for (int n = 0; n < 300 && acc < 0; n++) begin
         @(negedge clk);
         if (!m0_waitrequest) acc = cyc;
      end
      if (acc < 0) chk(0, "m0_timeout", 0, 1);
      @(posedge clk);
      #2 m0_read = 0;
   endtask

   task automatic m1_op(input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                        input logic [3:0] be, input logic [31:0] d, output int acc, output int waits);
      m1_address = a;
      m1_byteenable = be;
      m1_writedata = d;
      m1_read = rd;
      m1_write = wr;
      acc = -1;
      waits = 0;
      for (int n = 0; n < 300 && acc < 0; n++) begin
         @(negedge clk);
         if (!m1_waitrequest) acc = cyc;
         else if (!freeze) waits++;
      end
      if (acc < 0) chk(0, "m1_timeout", 0, 1);
      @(posedge clk);
      #2;
      m1_read = 0;
      m1_write = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, a1, w, r0, r1, w0, w1, op;
      reset_n = 0; freeze = 0; err_clr = 0;
      m0_read = 0; m0_address = '0;
      m1_read = 0; m1_write = 0; m1_address = '0; m1_byteenable = '0; m1_writedata = '0;
      d0 = 0; d1 = 0;
      idle(3);
      reset_n = 1;
      idle(1);
      m0_rd(16'h0010, a0);
      idle(2);
      // continuous m0 load: m1 waits MAX_WAIT cycles then gets in
      m0_address = 16'h0010;
      m0_read = 1;
      m1_op(0, 1, 16'h0004, 4'b0011, 32'h1234_5678, a1, w);
      m0_read = 0;
      chk(w == MAX_WAIT, "starve_wait", w, MAX_WAIT);
      m1_op(1, 0, 16'h0004, 4'hF, 0, a1, w);
      idle(2);
      fork
         m0_rd(16'h0014, a0);
         m1_op(1, 0, 16'h0015, 4'hF, 0, a1, w);
      join
      chk(a1 == a0 + 1, "m0_first_then_m1", a1 - a0, 1);
      idle(1);
      m1_op(0, 1, 16'(DEPTH), 4'hF, 32'hCAFE_F00D, a1, w);
      m1_op(1, 0, 16'd40000, 4'hF, 0, a1, w);
      m1_op(1, 0, 16'(DEPTH - 1), 4'hF, 0, a1, w);
      err_clr = 1;
      idle(1);
      err_clr = 0;
      idle(1);
      // freeze 5 cycles part-way through an m1 wait: counter must hold
      m0_address = 16'h0005;
      m0_read = 1;
      fork
         m1_op(1, 0, 16'h0006, 4'hF, 0, a1, w);
         begin
            idle(3);
            freeze = 1;
            idle(5);
            freeze = 0;
         end
      join
      m0_read = 0;
      chk(w == MAX_WAIT, "freeze_starve_hold", w, MAX_WAIT);
      idle(1);
      m1_op(0, 1, 16'hFFFF, 4'hF, 0, a1, w);
      m1_op(1, 0, 16'h0007, 4'hF, 0, a1, w);
      reset_n = 0;
      idle(2);
      reset_n = 1;
      idle(1);
      m0_rd(16'h0010, a0);
      idle(2);
      fork
         begin
            for (int k = 0; k < 250; k++) begin
               if ($urandom_range(0, 3) == 0) idle(1);
               m0_rd(rand_addr(), r0);
            end
            d0 = 1;
         end
         begin
            for (int k = 0; k < 250; k++) begin
               if ($urandom_range(0, 3) == 0) idle(1);
               op = $urandom_range(0, 4);
               m1_op(op < 2 || op == 4, op >= 2, rand_addr(), 4'($urandom), $urandom, r1, w1);
            end
            d1 = 1;
         end
         begin
            while (!(d0 && d1)) begin
               @(posedge clk);
               #2;
               freeze = $urandom_range(0, 15) == 0;
               err_clr = $urandom_range(0, 15) == 0;
            end
            freeze = 0;
            err_clr = 0;
         end
      join
      idle(4);
      @(negedge clk);
      chk(q[0].size() == 0, "m0_drain", q[0].size(), 0);
      chk(q[1].size() == 0, "m1_drain", q[1].size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
